seq_detector_multi: RTL and testbench

//  Multi-pattern serial sequence detector. Successor to the single-pattern masked detector.

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_det_channel.sv | 90 +++++++++
 rtl/seq_detector_multi.sv | 122 ++++++++++++
 tb/tb_seq_detector_multi.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the multi-pattern serial sequence detector.
package seq_det_pkg;

  localparam int unsigned MAX_N_DEF   = 32;
  localparam logic        MODE_OVL    = 1'b0;
  localparam logic        MODE_NONOVL = 1'b1;

  // Width needed to hold a length value in 0..max_n.
  function automatic int unsigned len_w(input int unsigned max_n);
    return $clog2(max_n + 1);
  endfunction

endpackage

// File: rtl/seq_det_channel.sv
// One pattern channel: config registers, availability tracking, masked compare
// and a saturating match counter.
module seq_det_channel
  import seq_det_pkg::*;
#(
  parameter  int unsigned MAX_N = MAX_N_DEF,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned LEN_W = len_w(MAX_N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept_i,
  input  logic             flush_i,
  input  logic [MAX_N-1:0] nh_i,
  input  logic [LEN_W-1:0] fill_i,
  input  logic             cfg_we_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  input  logic [MAX_N-1:0] cfg_pattern_i,
  input  logic             cfg_nonovl_i,
  input  logic             clear_cnt_i,
  output logic             fire_c_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_N);

  logic [LEN_W-1:0] len_q, len_d;
  logic [MAX_N-1:0] pat_q;
  logic             nonovl_q;
  logic [LEN_W-1:0] avail_q, avail_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MAX_N-1:0] mask;
  logic [LEN_W-1:0] avail_sel;
  logic             pat_eq;
  logic             enough;

  assign len_d = (cfg_len_i > LEN_MAX) ? LEN_MAX : cfg_len_i;

  always_comb begin
    mask = '0;
    for (int b = 0; b < MAX_N; b++) begin
      mask[b] = ((LEN_W+1)'(b) < {1'b0, len_q});
    end
  end

  // Length guard is evaluated one bit wider so avail+1 cannot overflow at MAX_N.
  assign pat_eq    = ((nh_i ^ pat_q) & mask) == '0;
  assign avail_sel = (nonovl_q == MODE_NONOVL) ? avail_q : fill_i;
  assign enough    = ({1'b0, avail_sel} + (LEN_W+1)'(1)) >= {1'b0, len_q};
  assign fire_c_o  = accept_i && (len_q != '0) && pat_eq && enough;

  always_comb begin
    avail_d = avail_q;
    if (flush_i || cfg_we_i || fire_c_o) begin
      avail_d = '0;
    end else if (accept_i && (avail_q != LEN_MAX)) begin
      avail_d = avail_q + LEN_W'(1);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear_cnt_i || cfg_we_i) begin
      cnt_d = '0;
    end else if (fire_c_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q    <= '0;
      pat_q    <= '0;
      nonovl_q <= MODE_OVL;
      avail_q  <= '0;
      cnt_q    <= '0;
    end else begin
      if (cfg_we_i) begin
        len_q    <= len_d;
        pat_q    <= cfg_pattern_i;
        nonovl_q <= cfg_nonovl_i;
      end
      avail_q <= avail_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detector_multi.sv
// Multi-pattern serial sequence detector: shared history/fill, per-channel
// matchers, registered match outputs with lowest-index priority.
module seq_detector_multi
  import seq_det_pkg::*;
#(
  parameter  int unsigned MAX_N   = MAX_N_DEF,
  parameter  int unsigned NUM_PAT = 4,
  parameter  int unsigned CNT_W   = 16,
  localparam int unsigned LEN_W   = len_w(MAX_N),
  localparam int unsigned SEL_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_valid_i,
  input  logic               bit_in_i,
  input  logic               flush_i,
  input  logic               cfg_we_i,
  input  logic [SEL_W-1:0]   cfg_sel_i,
  input  logic [LEN_W-1:0]   cfg_len_i,
  input  logic [MAX_N-1:0]   cfg_pattern_i,
  input  logic               cfg_nonovl_i,
  input  logic               clear_cnt_i,
  input  logic [SEL_W-1:0]   cnt_sel_i,
  output logic [NUM_PAT-1:0] match_vec_o,
  output logic               match_any_o,
  output logic [SEL_W-1:0]   match_idx_o,
  output logic [CNT_W-1:0]   cnt_out_o
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_N);

  // Reset asserts asynchronously and releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_sync_q <= 2'b11;
    else     rst_sync_q <= {rst_sync_q[0], 1'b0};
  end
  assign rst_int = rst_sync_q[1];

  logic [MAX_N-2:0]   hist_q;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [MAX_N-1:0]   nh;
  logic               accept;
  logic [NUM_PAT-1:0] fire_c;
  logic [CNT_W-1:0]   cnt_arr [NUM_PAT];
  logic [SEL_W-1:0]   idx_d;

  // A flush in the same cycle drops the incoming bit.
  assign accept = bit_valid_i && !flush_i;
  assign nh     = {hist_q, bit_in_i};

  always_comb begin
    fill_d = fill_q;
    if (flush_i) begin
      fill_d = '0;
    end else if (accept && (fill_q != FILL_MAX)) begin
      fill_d = fill_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      if (flush_i)     hist_q <= '0;
      else if (accept) hist_q <= nh[MAX_N-2:0];
      fill_q <= fill_d;
    end
  end

  for (genvar g = 0; g < NUM_PAT; g++) begin : g_ch
    seq_det_channel #(
      .MAX_N (MAX_N),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst_int),
      .accept_i      (accept),
      .flush_i       (flush_i),
      .nh_i          (nh),
      .fill_i        (fill_q),
      .cfg_we_i      (cfg_we_i && (cfg_sel_i == SEL_W'(g))),
      .cfg_len_i     (cfg_len_i),
      .cfg_pattern_i (cfg_pattern_i),
      .cfg_nonovl_i  (cfg_nonovl_i),
      .clear_cnt_i   (clear_cnt_i),
      .fire_c_o      (fire_c[g]),
      .cnt_o         (cnt_arr[g])
    );
  end

  always_comb begin
    idx_d = '0;
    for (int i = int'(NUM_PAT) - 1; i >= 0; i--) begin
      if (fire_c[i]) idx_d = SEL_W'(i);
    end
  end

  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      match_vec_o <= '0;
      match_any_o <= 1'b0;
      match_idx_o <= '0;
    end else begin
      match_vec_o <= fire_c;
      match_any_o <= |fire_c;
      match_idx_o <= idx_d;
    end
  end

  // Unmatched selects (>= NUM_PAT) read back as zero.
  always_comb begin
    cnt_out_o = '0;
    for (int i = 0; i < NUM_PAT; i++) begin
      if (cnt_sel_i == SEL_W'(i)) cnt_out_o = cnt_arr[i];
    end
  end

endmodule

// File: tb/tb_seq_detector_multi.sv
// Bench for seq_detector_multi: directed scenarios plus random traffic checked
// against a queue-based behavioural model of the detector.
module tb_seq_detector_multi;

  localparam int MAXN = 32;
  localparam int NP   = 4;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic        clk, rst;
  logic        bv, bin, fl, we, nonovl, clr;
  logic [1:0]  sel, csel;
  logic [5:0]  len;
  logic [31:0] pat;
  logic [3:0]  match_vec;
  logic        match_any;
  logic [1:0]  match_idx;
  logic [3:0]  cnt_out;

  seq_detector_multi #(.MAX_N(MAXN), .NUM_PAT(NP), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .bit_valid_i   (bv),
    .bit_in_i      (bin),
    .flush_i       (fl),
    .cfg_we_i      (we),
    .cfg_sel_i     (sel),
    .cfg_len_i     (len),
    .cfg_pattern_i (pat),
    .cfg_nonovl_i  (nonovl),
    .clear_cnt_i   (clr),
    .cnt_sel_i     (csel),
    .match_vec_o   (match_vec),
    .match_any_o   (match_any),
    .match_idx_o   (match_idx),
    .cnt_out_o     (cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: bits accepted since the last flush/reset, newest at index 0.
  bit          q[$];
  int          m_len    [NP];
  logic [31:0] m_pat    [NP];
  bit          m_nonovl [NP];
  int          m_since  [NP];
  int          m_cnt    [NP];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < NP; i++) begin
      m_len[i] = 0; m_pat[i] = '0; m_nonovl[i] = 0; m_since[i] = 0; m_cnt[i] = 0;
    end
  endtask

  function automatic bit model_fire(input int i, input bit b);
    int av;
    bit h;
    if (m_len[i] == 0) return 1'b0;
    av = m_nonovl[i] ? m_since[i] : q.size();
    if (av + 1 < m_len[i]) return 1'b0;
    for (int j = 0; j < m_len[i]; j++) begin
      h = (j == 0) ? b : q[j-1];
      if (h != m_pat[i][j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: predict from pre-edge state, advance the model, compare outputs.
  task automatic tick();
    bit t_bv, t_bin, t_fl, t_we, t_nonovl, t_clr;
    int t_sel, t_len, eidx;
    logic [31:0] t_pat;
    bit [3:0] ef;
    t_bv = bv; t_bin = bin; t_fl = fl; t_we = we; t_nonovl = nonovl; t_clr = clr;
    t_sel = int'(sel); t_len = int'(len); t_pat = pat;
    ef = '0;
    if (t_bv && !t_fl)
      for (int i = 0; i < NP; i++) ef[i] = model_fire(i, t_bin);
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) begin
      if (t_clr || (t_we && t_sel == i)) m_cnt[i] = 0;
      else if (ef[i] && m_cnt[i] < CMAX) m_cnt[i]++;
      if (t_fl || (t_we && t_sel == i) || ef[i]) m_since[i] = 0;
      else if (t_bv) m_since[i]++;
    end
    if (t_fl) q.delete();
    else if (t_bv) begin
      q.push_front(t_bin);
      if (q.size() > MAXN) void'(q.pop_back());
    end
    if (t_we) begin
      m_len[t_sel]    = (t_len > MAXN) ? MAXN : t_len;
      m_pat[t_sel]    = t_pat;
      m_nonovl[t_sel] = t_nonovl;
    end
    eidx = 0;
    for (int i = NP - 1; i >= 0; i--) if (ef[i]) eidx = i;
    chk("match_vec", int'(match_vec), int'(ef));
    chk("match_any", int'(match_any), int'(|ef));
    chk("match_idx", int'(match_idx), eidx);
    chk("cnt_out", int'(cnt_out), m_cnt[int'(csel)]);
    bv = 0; bin = 0; fl = 0; we = 0; nonovl = 0; clr = 0; sel = '0; len = '0; pat = '0;
  endtask

  task automatic send(input bit b);
    bv = 1'b1; bin = b; tick();
  endtask

  task automatic cfg_ch(input int ch, input int l, input logic [31:0] p, input bit n);
    we = 1'b1; sel = 2'(ch); len = 6'(l); pat = p; nonovl = n; tick();
  endtask

  task automatic do_flush();
    fl = 1'b1; tick();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bv = 0; bin = 0; fl = 0; we = 0; nonovl = 0; clr = 0;
    sel = '0; csel = '0; len = '0; pat = '0;
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #3;
    chk("rst_vec", int'(match_vec), 0);
    chk("rst_any", int'(match_any), 0);
    chk("rst_idx", int'(match_idx), 0);
    chk("rst_cnt", int'(cnt_out), 0);
    #10;
    release_reset();

    // Disabled channels never match
    for (int k = 0; k < 64; k++) send(1'($urandom_range(0, 1)));
    for (int s = 0; s < NP; s++) begin
      csel = 2'(s); tick();
      chk("t1_cnt_zero", int'(cnt_out), 0);
    end

    // Overlapping 1011 on ch0
    cfg_ch(0, 4, 32'b1011, 0);
    do_flush();
    begin
      bit s2 [7] = '{1, 0, 1, 1, 0, 1, 1};
      for (int k = 1; k <= 7; k++) begin
        send(s2[k-1]);
        chk("t2_pulse", int'(match_vec[0]), (k == 4 || k == 7) ? 1 : 0);
      end
    end
    csel = 2'd0; tick();
    chk("t2_cnt", int'(cnt_out), 2);

    // 11 on ch1, overlap then non-overlap
    cfg_ch(1, 2, 32'b11, 0);
    do_flush();
    for (int k = 1; k <= 4; k++) begin
      send(1'b1);
      chk("t3_ovl", int'(match_vec[1]), (k >= 2) ? 1 : 0);
    end
    cfg_ch(1, 2, 32'b11, 1);
    do_flush();
    for (int k = 1; k <= 4; k++) begin
      send(1'b1);
      chk("t3_nonovl", int'(match_vec[1]), (k == 2 || k == 4) ? 1 : 0);
    end

    // Fill guard with 8 zeros on ch2, and flush restarting the guard
    cfg_ch(2, 8, 32'h00, 0);
    do_flush();
    for (int k = 1; k <= 8; k++) begin
      send(1'b0);
      chk("t4_fill", int'(match_vec[2]), (k == 8) ? 1 : 0);
    end
    do_flush();
    for (int k = 1; k <= 5; k++) send(1'b0);
    do_flush();
    for (int k = 1; k <= 8; k++) begin
      send(1'b0);
      chk("t4_flush", int'(match_vec[2]), (k == 8) ? 1 : 0);
    end

    // Simultaneous ch1/ch3 match, saturation, clear on fire
    cfg_ch(1, 2, 32'b11, 0);
    cfg_ch(3, 3, 32'b011, 0);
    do_flush();
    send(1'b0); send(1'b1); send(1'b1);
    chk("t5_vec", int'(match_vec), 4'b1010);
    chk("t5_idx", int'(match_idx), 1);
    chk("t5_any", int'(match_any), 1);
    csel = 2'd1;
    for (int k = 0; k < 20; k++) send(1'b1);
    chk("t5_sat", int'(cnt_out), 15);
    clr = 1'b1; send(1'b1);
    chk("t5_clr_fire", int'(match_vec[1]), 1);
    chk("t5_clr_cnt", int'(cnt_out), 0);

    // Config write on a completing bit uses the old config; len 40 clamps to 32
    cfg_ch(0, 4, 32'b1011, 0);
    do_flush();
    csel = 2'd0;
    send(1'b1); send(1'b0); send(1'b1);
    bv = 1'b1; bin = 1'b1; we = 1'b1; sel = 2'd0; len = 6'd40; pat = 32'hFFFF_FFFF; nonovl = 1'b0;
    tick();
    chk("t6_old_cfg", int'(match_vec[0]), 1);
    chk("t6_cnt", int'(cnt_out), 0);
    do_flush();
    for (int k = 1; k <= 32; k++) begin
      send(1'b1);
      chk("t6_clamp", int'(match_vec[0]), (k == 32) ? 1 : 0);
    end
    chk("t6_cnt1", int'(cnt_out), 1);

    // Reset between edges clears outputs without a clock
    #2 rst = 1'b1;
    #1;
    chk("arst_vec", int'(match_vec), 0);
    chk("arst_any", int'(match_any), 0);
    chk("arst_cnt", int'(cnt_out), 0);
    model_reset();
    release_reset();
    cfg_ch(0, 4, 32'b1011, 0);
    begin
      bit s7 [4] = '{1, 0, 1, 1};
      for (int k = 1; k <= 4; k++) begin
        send(s7[k-1]);
        chk("post_rst", int'(match_vec[0]), (k == 4) ? 1 : 0);
      end
    end

    // Random traffic against the model
    for (int i = 0; i < NP; i++)
      cfg_ch(i, $urandom_range(1, 4), $urandom, 1'($urandom_range(0, 1)));
    for (int n = 0; n < 2000; n++) begin
      bv     = ($urandom_range(0, 3) != 0);
      bin    = 1'($urandom_range(0, 1));
      fl     = ($urandom_range(0, 39) == 0);
      we     = ($urandom_range(0, 29) == 0);
      sel    = 2'($urandom_range(0, 3));
      len    = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 5));
      pat    = $urandom;
      nonovl = 1'($urandom_range(0, 1));
      clr    = ($urandom_range(0, 49) == 0);
      csel   = 2'($urandom_range(0, 3));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
